// File: rtl/dmem_lsu_ctrl.sv
// Handshaked load/store unit for the MEM stage: word-organised data array,
// RV32I funct3 decode, byte-lane stores and sign/zero-extended loads.
//
// state | meaning
// IDLE  | ready for a request (unless halted)
// WAIT  | latency counter running toward 0
// RESP  | response presented, waiting for resp_ready
module dmem_lsu_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int DEPTH    = 512,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              accept, resp_load;

    logic [1:0]        off;
    logic [IDX_W-1:0]  widx;
    logic [MEM_AW-1:0] midx;
    logic              f3_ok, align_ok, in_range, acc_err;
    logic [3:0]        be, be_sh;
    logic [31:0]       wdata_rep;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ld_word;
    logic [2:0]        p_f3;
    logic [1:0]        p_off;
    logic              p_we, p_err;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       lane_data;

    assign off  = req_addr[1:0];
    assign widx = req_addr[ADDR_W-1:2];
    assign midx = widx[MEM_AW-1:0];

    always_comb begin
        in_range = int'(widx) < DEPTH;
        if (req_we)
            f3_ok = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
        else
            f3_ok = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
        case (req_funct3[1:0])
            2'b00: begin
                align_ok  = 1'b1;
                be        = 4'b0001;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                align_ok  = !off[0];
                be        = 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                align_ok  = (off == 2'b00);
                be        = 4'b1111;
                wdata_rep = req_wdata;
            end
        endcase
        be_sh   = be << off;
        acc_err = !(f3_ok && align_ok && in_range);
    end

    assign req_ready  = (state_q == IDLE) && !halt && !rst;
    assign resp_valid = (state_q == RESP);
    assign accept     = req_valid && req_ready;

    // Array has no reset; loads snapshot the word at accept, which is safe
    // because nothing can write while the load is outstanding.
    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be_sh[i])
                    mem[midx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
        if (accept && !req_we)
            ld_word <= mem[midx];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        resp_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: begin
                if (!halt) begin
                    if (cnt_q == 2'd0) begin
                        resp_load = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_v = ld_word[8*p_off +: 8];
        half_v = ld_word[16*p_off[1] +: 16];
        case (p_f3)
            3'b000:  lane_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  lane_data = {24'h0, byte_v};
            3'b001:  lane_data = {{16{half_v[15]}}, half_v};
            3'b101:  lane_data = {16'h0, half_v};
            default: lane_data = ld_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            p_f3       <= 3'd0;
            p_off      <= 2'd0;
            p_we       <= 1'b0;
            p_err      <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                p_f3  <= req_funct3;
                p_off <= off;
                p_we  <= req_we;
                p_err <= acc_err;
            end
            if (resp_load) begin
                resp_rdata <= (p_we || p_err) ? 32'h0 : lane_data;
                resp_err   <= p_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: directed vector table, latency/halt/reset corner
// sequences and random accesses against a byte-addressed memory model.
module tb_dmem_lsu_ctrl;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT with READ_LAT=1
    logic              halt, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata, resp_rdata;
    logic [2:0]        req_funct3;

    // DUT with READ_LAT=3
    logic              halt_3, req_valid_3, req_ready_3, req_we_3, resp_valid_3, resp_ready_3, resp_err_3;
    logic [ADDR_W-1:0] req_addr_3;
    logic [31:0]       req_wdata_3, resp_rdata_3;
    logic [2:0]        req_funct3_3;

    dmem_lsu_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1)) u1 (
        .clk(clk), .rst(rst), .halt(halt),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_lsu_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(3)) u3 (
        .clk(clk), .rst(rst), .halt(halt_3),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_we(req_we_3),
        .req_addr(req_addr_3), .req_wdata(req_wdata_3), .req_funct3(req_funct3_3),
        .resp_valid(resp_valid_3), .resp_ready(resp_ready_3),
        .resp_rdata(resp_rdata_3), .resp_err(resp_err_3)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain byte-addressed memory.
    logic [7:0] ref_mem [0:4095];

    function automatic void model(input logic we, input logic [ADDR_W-1:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output logic [31:0] rd, output logic er);
        int size = 1 << f3[1:0];
        int ai   = int'(a);
        er = 1'b0;
        rd = 32'h0;
        if (we && f3 > 3'd2) er = 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) er = 1'b1;
        if (ai % size != 0) er = 1'b1;
        if (ai / 4 >= DEPTH) er = 1'b1;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[ai+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[ai+i];
                if (!f3[2] && size < 4 && rd[8*size-1])
                    for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic access(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd, output logic er,
                          output int lat);
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    typedef struct {
        string             name;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wd;
        logic [2:0]        f3;
        logic [31:0]       exp_rd;
        logic              exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, seen;
        int          lat, g;

        rst = 1'b1;
        halt = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; resp_ready = 1'b1;
        halt_3 = 1'b0; req_valid_3 = 1'b0; req_we_3 = 1'b0; req_addr_3 = '0;
        req_wdata_3 = '0; req_funct3_3 = '0; resp_ready_3 = 1'b1;

        vecs.push_back('{"sw_010",      1'b1, 12'h010, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{"lw_010",      1'b0, 12'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"sb_012",      1'b1, 12'h012, 32'h000000A5, 3'b000, 32'h0,        1'b0});
        vecs.push_back('{"lw_010_b",    1'b0, 12'h010, 32'h0,        3'b010, 32'hDEA5BEEF, 1'b0});
        vecs.push_back('{"lb_012",      1'b0, 12'h012, 32'h0,        3'b000, 32'hFFFFFFA5, 1'b0});
        vecs.push_back('{"lbu_012",     1'b0, 12'h012, 32'h0,        3'b100, 32'h000000A5, 1'b0});
        vecs.push_back('{"sw_020",      1'b1, 12'h020, 32'h11223344, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{"sh_022",      1'b1, 12'h022, 32'h00008001, 3'b001, 32'h0,        1'b0});
        vecs.push_back('{"lh_022",      1'b0, 12'h022, 32'h0,        3'b001, 32'hFFFF8001, 1'b0});
        vecs.push_back('{"lhu_022",     1'b0, 12'h022, 32'h0,        3'b101, 32'h00008001, 1'b0});
        vecs.push_back('{"lw_020",      1'b0, 12'h020, 32'h0,        3'b010, 32'h80013344, 1'b0});
        vecs.push_back('{"sw_014",      1'b1, 12'h014, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{"lw_011_mis",  1'b0, 12'h011, 32'h0,        3'b010, 32'h0,        1'b1});
        vecs.push_back('{"sh_013_mis",  1'b1, 12'h013, 32'hFFFFFFFF, 3'b001, 32'h0,        1'b1});
        vecs.push_back('{"sw_011_mis",  1'b1, 12'h011, 32'h0,        3'b010, 32'h0,        1'b1});
        vecs.push_back('{"st_f3_100",   1'b1, 12'h014, 32'h0,        3'b100, 32'h0,        1'b1});
        vecs.push_back('{"ld_f3_011",   1'b0, 12'h010, 32'h0,        3'b011, 32'h0,        1'b1});
        vecs.push_back('{"lw_oor",      1'b0, 12'h800, 32'h0,        3'b010, 32'h0,        1'b1});
        vecs.push_back('{"sw_oor",      1'b1, 12'h800, 32'h55555555, 3'b010, 32'h0,        1'b1});
        vecs.push_back('{"lw_010_keep", 1'b0, 12'h010, 32'h0,        3'b010, 32'hDEA5BEEF, 1'b0});
        vecs.push_back('{"lw_014_keep", 1'b0, 12'h014, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{"lw_000_alias",1'b0, 12'h000, 32'h0,        3'b010, 32'h0,        1'b0});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'h0, req_ready},  32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_resp_err",   {31'h0, resp_err},   32'h0);
        @(negedge clk) rst = 1'b0;

        // seed word 0 so the out-of-range store at 0x800 can be shown not to alias it
        access(1'b1, 12'h000, 32'h0, 3'b010, rd, er, lat);

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].f3, rd, er, lat);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            check({vecs[i].name, "_err"},   {31'h0, er}, {31'h0, vecs[i].exp_err});
            check({vecs[i].name, "_lat"},   lat, 32'd1);
        end

        // READ_LAT=3: plain store, then a load with halt in WAIT and backpressure in RESP
        @(negedge clk);
        req_valid_3 = 1'b1; req_we_3 = 1'b1; req_addr_3 = 12'h040;
        req_wdata_3 = 32'h0BADF00D; req_funct3_3 = 3'b010;
        @(posedge clk);
        #1 req_valid_3 = 1'b0;
        lat = 0;
        while (!resp_valid_3 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("l3_sw_lat", lat, 32'd3);
        check("l3_sw_err", {31'h0, resp_err_3}, 32'h0);

        @(negedge clk);
        @(negedge clk);
        check("l3_ready_idle", {31'h0, req_ready_3}, 32'h1);
        req_valid_3 = 1'b1; req_we_3 = 1'b0; req_addr_3 = 12'h040; req_funct3_3 = 3'b010;
        resp_ready_3 = 1'b0;
        @(posedge clk);
        #1 req_valid_3 = 1'b0;
        halt_3 = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!resp_valid_3 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 2) halt_3 = 1'b0;
            if (req_ready_3) seen = 1'b1;
        end
        check("l3_halt_lat", lat, 32'd5);
        for (int i = 0; i < 4; i++) begin
            check("l3_hold_valid", {31'h0, resp_valid_3}, 32'h1);
            check("l3_hold_rdata", resp_rdata_3, 32'h0BADF00D);
            if (req_ready_3) seen = 1'b1;
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        check("l3_ready_low", {31'h0, seen}, 32'h0);
        halt_3 = 1'b1;
        resp_ready_3 = 1'b1;
        @(posedge clk);
        #1;
        check("l3_halt_handshake", {31'h0, resp_valid_3}, 32'h0);
        check("l3_halt_blocks",    {31'h0, req_ready_3},  32'h0);
        halt_3 = 1'b0;
        #1;
        check("l3_ready_after", {31'h0, req_ready_3}, 32'h1);

        // fill the in-range array so random loads have known contents
        for (int w = 0; w < DEPTH; w++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b1, ADDR_W'(w * 4), d, 3'b010, exp_rd, exp_er);
            access(1'b1, ADDR_W'(w * 4), d, 3'b010, rd, er, lat);
        end

        for (int n = 0; n < 300; n++) begin
            logic              we;
            logic [ADDR_W-1:0] a;
            logic [31:0]       d;
            logic [2:0]        f3;
            we = 1'($urandom_range(0, 1));
            a  = ADDR_W'($urandom_range(0, 12'h87F));
            d  = $urandom;
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            model(we, a, d, f3, exp_rd, exp_er);
            access(we, a, d, f3, rd, er, lat);
            check("rnd_rdata", rd, exp_rd);
            check("rnd_err", {31'h0, er}, {31'h0, exp_er});
            check("rnd_lat", lat, 32'd1);
        end

        // reset during WAIT of a load following a committed store
        access(1'b1, 12'h030, 32'h12345678, 3'b010, rd, er, lat);
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h030; req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rstw_req_ready",  {31'h0, req_ready},  32'h0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 if (resp_valid) seen = 1'b1;
        end
        check("rstw_no_resp", {31'h0, seen}, 32'h0);
        check("rstw_ready",   {31'h0, req_ready}, 32'h1);
        access(1'b0, 12'h030, 32'h0, 3'b010, rd, er, lat);
        check("rstw_lw_030", rd, 32'h12345678);
        check("rstw_lw_err", {31'h0, er}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
